ch_best_select: RTL and testbench

- Consumer on the read port of the cluster-head memory bank.
- Bank holds 16-bit Q-value words; entry k occupies byte indices 2k and 2k+1, high byte first.
- On `start`, the block walks entries 0..num_valid-1, one per clock, and reports the entry with the highest nonzero Q-value.
- The RL node logic uses the result to pick its next-hop cluster head.

---
 rtl/ch_best_select.sv | 142 ++++++++++++++
 tb/tb_ch_best_select.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_best_select.sv
// ----------------------------------------------------------------------------
// ch_best_select
//   Scans the cluster-head memory bank (16-bit Q-value words, entry k at byte
//   indices 2k/2k+1) and reports the entry with the best nonzero Q-value.
//   Default build picks the largest word. With CH_SELECT_MIN_EN defined the
//   smallest nonzero word (cost metric) is picked instead.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous reset, active-high
//   start        begin a scan; only sampled in IDLE
//   num_valid    entries to scan (0..16, larger values clamp to 16)
//   mem_index    byte index to the bank, always even ({k,1'b0})
//   mem_rd_data  combinational bank read data for mem_index
//   busy         high while in SCAN and DONE
//   done         one-cycle pulse, results valid
//   found        at least one nonzero entry was seen
//   best_entry   entry number of the winner
//   best_q       winning Q-value
//
// Handshake: start is a level sampled once per clock while IDLE; a sampled
// start launches exactly one scan that ends with exactly one done pulse.
// start seen while a scan is in flight is dropped, never queued.
// ----------------------------------------------------------------------------
module ch_best_select #(
    parameter int NUM_ENTRIES = 16,
    parameter int WORD_WIDTH  = 16,
    parameter int IDX_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            num_valid,
    output logic [IDX_WIDTH-1:0]  mem_index,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [3:0]            best_entry,
    output logic [WORD_WIDTH-1:0] best_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] MAX_N = 5'(NUM_ENTRIES);

    state_t                  r_state;
    logic [4:0]              r_n;
    logic [3:0]              r_k;
    logic [IDX_WIDTH-1:0]    r_mem_index;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_found;
    logic [3:0]              r_best_entry;
    logic [WORD_WIDTH-1:0]   r_best_q;

    logic [4:0]              w_n_clamped;
    logic                    w_last;
    logic                    w_better;
    logic                    w_take;

    assign w_n_clamped = (num_valid > MAX_N) ? MAX_N : num_valid;
    assign w_last      = ({1'b0, r_k} == (r_n - 5'd1));

    // Strict comparison so that ties keep the lower entry number.
`ifdef CH_SELECT_MIN_EN
    assign w_better = (mem_rd_data < r_best_q);
`else
    assign w_better = (mem_rd_data > r_best_q);
`endif

    // Zero words are empty entries and never win.
    assign w_take = (mem_rd_data != '0) && (!r_found || w_better);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_n          <= '0;
            r_k          <= '0;
            r_mem_index  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_best_entry <= '0;
            r_best_q     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_index <= '0;
                    if (start) begin
                        r_n          <= w_n_clamped;
                        r_k          <= '0;
                        r_found      <= 1'b0;
                        r_best_entry <= '0;
                        r_best_q     <= '0;
                        r_busy       <= 1'b1;
                        // An empty scan skips straight to the done pulse.
                        r_state      <= (w_n_clamped != 5'd0) ? ST_SCAN : ST_DONE;
                    end
                end
                ST_SCAN: begin
                    if (w_take) begin
                        r_found      <= 1'b1;
                        r_best_entry <= r_k;
                        r_best_q     <= mem_rd_data;
                    end
                    if (w_last) begin
                        r_mem_index <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_k         <= r_k + 4'd1;
                        r_mem_index <= IDX_WIDTH'({r_k + 4'd1, 1'b0});
                    end
                end
                ST_DONE: begin
                    // done is registered on leaving DONE, so it shows in the
                    // first IDLE cycle while results are already final.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_index  = r_mem_index;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign best_entry = r_best_entry;
    assign best_q     = r_best_q;

endmodule

// File: tb/tb_ch_best_select.sv
// ----------------------------------------------------------------------------
// tb_ch_best_select
//   Directed bench for ch_best_select. A behavioural bank array answers
//   mem_index combinationally. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ch_best_select;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  num_valid;
    logic [4:0]  mem_index;
    logic [15:0] mem_rd_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [3:0]  best_entry;
    logic [15:0] best_q;

    logic [15:0] bank [0:15];
    int          idx_log [0:19];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          dn;

    ch_best_select #(
        .NUM_ENTRIES(16),
        .WORD_WIDTH (16),
        .IDX_WIDTH  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_valid  (num_valid),
        .mem_index  (mem_index),
        .mem_rd_data(mem_rd_data),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_entry (best_entry),
        .best_q     (best_q)
    );

    assign mem_rd_data = bank[mem_index[4:1]];

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bank();
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
    endtask

    // Launches one scan and returns the number of rising edges from the
    // start edge until done is seen, plus the total done pulses observed.
    task automatic run_scan(input logic [4:0] n, output int cycles, output int dones);
        @(negedge clk);
        start     = 1'b1;
        num_valid = n;
        @(negedge clk);
        start     = 1'b0;
        num_valid = 5'($urandom_range(0, 31));
        cycles    = 0;
        dones     = 0;
        for (int i = 0; i < 20; i++) idx_log[i] = -1;
        idx_log[0] = int'(mem_index);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cycles++;
            if (cycles < 20) idx_log[cycles] = int'(mem_index);
            if (done) begin
                dones++;
                break;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_valid = 5'd0;
        clear_bank();

        // reset state
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_best_entry", 32'(best_entry), 32'd0);
        check("rst_best_q", 32'(best_q), 32'd0);
        check("rst_mem_index", 32'(mem_index), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic three-entry scan
        bank[0] = 16'h0010;
        bank[1] = 16'h00A0;
        bank[2] = 16'h0050;
        run_scan(5'd3, cyc, dn);
        check("t1_latency", 32'(cyc), 32'd4);
        check("t1_dones", 32'(dn), 32'd1);
        check("t1_idx0", 32'(idx_log[0]), 32'd0);
        check("t1_idx1", 32'(idx_log[1]), 32'd2);
        check("t1_idx2", 32'(idx_log[2]), 32'd4);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_found", 32'(found), 32'd1);
`ifdef CH_SELECT_MIN_EN
        check("t1_best_entry", 32'(best_entry), 32'd0);
        check("t1_best_q", 32'(best_q), 32'h0010);
`else
        check("t1_best_entry", 32'(best_entry), 32'd1);
        check("t1_best_q", 32'(best_q), 32'h00A0);
`endif

        // ties over a full 16-entry scan
        for (int i = 0; i < 16; i++) bank[i] = 16'h0001;
        bank[3] = 16'h1234;
        bank[7] = 16'h1234;
        run_scan(5'd16, cyc, dn);
        check("t2_latency", 32'(cyc), 32'd17);
        check("t2_dones", 32'(dn), 32'd1);
        check("t2_found", 32'(found), 32'd1);
`ifdef CH_SELECT_MIN_EN
        check("t2_best_entry", 32'(best_entry), 32'd0);
        check("t2_best_q", 32'(best_q), 32'h0001);
`else
        check("t2_best_entry", 32'(best_entry), 32'd3);
        check("t2_best_q", 32'(best_q), 32'h1234);
`endif

        // all-zero bank: previous results must be cleared
        clear_bank();
        run_scan(5'd8, cyc, dn);
        check("t3_latency", 32'(cyc), 32'd9);
        check("t3_found", 32'(found), 32'd0);
        check("t3_best_entry", 32'(best_entry), 32'd0);
        check("t3_best_q", 32'(best_q), 32'd0);

        // empty scan after a nonzero one
        bank[0] = 16'h0042;
        run_scan(5'd1, cyc, dn);
        check("t4_pre_found", 32'(found), 32'd1);
        run_scan(5'd0, cyc, dn);
        check("t4_latency", 32'(cyc), 32'd1);
        check("t4_dones", 32'(dn), 32'd1);
        check("t4_found", 32'(found), 32'd0);
        check("t4_best_entry", 32'(best_entry), 32'd0);
        check("t4_best_q", 32'(best_q), 32'd0);

        // num_valid clamp
        clear_bank();
        bank[15] = 16'hFFFF;
        run_scan(5'd20, cyc, dn);
        check("t5_latency", 32'(cyc), 32'd17);
        check("t5_idx_max", 32'(idx_log[15]), 32'd30);
        check("t5_idx_done", 32'(idx_log[16]), 32'd0);
        check("t5_found", 32'(found), 32'd1);
        check("t5_best_entry", 32'(best_entry), 32'd15);
        check("t5_best_q", 32'(best_q), 32'hFFFF);

        // async reset mid-scan
        for (int i = 0; i < 8; i++) bank[i] = 16'(16'h0100 + i);
        @(negedge clk);
        start     = 1'b1;
        num_valid = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_idx_k5", 32'(mem_index), 32'd10);
        check("t6_busy_k5", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_found", 32'(found), 32'd0);
        check("t6_rst_best_q", 32'(best_q), 32'd0);
        check("t6_rst_best_entry", 32'(best_entry), 32'd0);
        check("t6_rst_mem_index", 32'(mem_index), 32'd0);
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("t6_no_done", 32'(dn), 32'd0);
        clear_bank();
        bank[0] = 16'h0003;
        bank[1] = 16'h0007;
        run_scan(5'd2, cyc, dn);
        check("t6_new_latency", 32'(cyc), 32'd3);
        check("t6_new_found", 32'(found), 32'd1);
`ifdef CH_SELECT_MIN_EN
        check("t6_new_best_entry", 32'(best_entry), 32'd0);
        check("t6_new_best_q", 32'(best_q), 32'h0003);
`else
        check("t6_new_best_entry", 32'(best_entry), 32'd1);
        check("t6_new_best_q", 32'(best_q), 32'h0007);
`endif

        // start re-pulsed mid-scan is ignored
        clear_bank();
        bank[0] = 16'h0100;
        bank[1] = 16'h0200;
        bank[2] = 16'h0300;
        bank[3] = 16'h0050;
        bank[4] = 16'h0400;
        bank[5] = 16'h0900;
        bank[6] = 16'hF000;
        @(negedge clk);
        start     = 1'b1;
        num_valid = 5'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_idx_k2", 32'(mem_index), 32'd4);
        start     = 1'b1;
        num_valid = 5'd3;
        @(negedge clk);
        start = 1'b0;
        dn  = 0;
        cyc = 3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dn++;
                if (dn == 1) check("t7_latency", 32'(cyc), 32'd7);
            end
        end
        check("t7_dones", 32'(dn), 32'd1);
        check("t7_found", 32'(found), 32'd1);
`ifdef CH_SELECT_MIN_EN
        check("t7_best_entry", 32'(best_entry), 32'd3);
        check("t7_best_q", 32'(best_q), 32'h0050);
`else
        check("t7_best_entry", 32'(best_entry), 32'd5);
        check("t7_best_q", 32'(best_q), 32'h0900);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
